// File: rtl/mmio_timer_if.sv
// Data-bus view of the timer peripheral: core-side write strobe, address and data,
// plus the combinational read word, window select and interrupt level back to the core.
interface mmio_timer_if;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        sel;
   logic        irq;

   modport master (output we, output a, output wd, input rd, input sel, input irq);
   modport slave  (input we, input a, input wd, output rd, output sel, output irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit up-counter with compare match flag and level irq.
// Reads are combinational from the decoded 32-byte window; writes land on the next rising edge.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
   parameter int          PRE_W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   mmio_timer_if.slave  bus
);
   localparam int NREG         = 8;
   localparam int OFF_CTRL     = 0;
   localparam int OFF_PRESCALE = 1;
   localparam int OFF_COMPARE  = 2;
   localparam int OFF_COUNT    = 3;
   localparam int OFF_STATUS   = 4;
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   logic             en_reg,       en_next;
   logic             reload_reg,   reload_next;
   logic             irq_en_reg,   irq_en_next;
   logic [PRE_W-1:0] prescale_reg, prescale_next;
   logic [PRE_W-1:0] pre_cnt_reg,  pre_cnt_next;
   logic [31:0]      compare_reg,  compare_next;
   logic [31:0]      count_reg,    count_next;
   logic             match_reg,    match_next;

   logic             sel;
   logic [2:0]       offset;
   logic [NREG-1:0]  wr_stb;
   logic             stop_wr;
   logic             tick;
   logic             hit;
   logic [31:0]      rd_word [NREG];
   logic             unused_addr_lsbs;

   assign sel    = (bus.a[31:5] == BASE_ADDR[31:5]);
   assign offset = bus.a[4:2];
   assign unused_addr_lsbs = &{1'b0, bus.a[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_dec
         assign wr_stb[gi] = bus.we & sel & (offset == 3'(gi));
      end
   endgenerate

   // A CTRL write that clears EN suppresses the tick on its own edge, so COUNT holds from then on.
   assign stop_wr = wr_stb[OFF_CTRL] & ~bus.wd[0];
   assign tick    = en_reg & (pre_cnt_reg == prescale_reg) & ~stop_wr;
   assign hit     = tick & (count_reg == compare_reg);

   always_comb begin
      en_next       = en_reg;
      reload_next   = reload_reg;
      irq_en_next   = irq_en_reg;
      prescale_next = prescale_reg;
      compare_next  = compare_reg;
      count_next    = count_reg;

      if (wr_stb[OFF_CTRL]) begin
         en_next     = bus.wd[0];
         reload_next = bus.wd[1];
         irq_en_next = bus.wd[2];
      end
      if (wr_stb[OFF_PRESCALE]) begin
         prescale_next = bus.wd[PRE_W-1:0];
      end
      if (wr_stb[OFF_COMPARE]) begin
         compare_next = bus.wd;
      end

      if (tick | ~en_reg | stop_wr | wr_stb[OFF_PRESCALE]) begin
         pre_cnt_next = '0;
      end else begin
         pre_cnt_next = pre_cnt_reg + PRE_ONE;
      end

      if (tick) begin
         if (hit) begin
            if (reload_reg) begin
               count_next = '0;
            end
         end else begin
            count_next = count_reg + 32'd1;
         end
      end
      // The CPU's load wins over the tick's update of the counter.
      if (wr_stb[OFF_COUNT]) begin
         count_next = bus.wd;
      end

      // A match on the same edge as a clear survives, so no event is lost.
      match_next = hit | (match_reg & ~(wr_stb[OFF_STATUS] & bus.wd[0]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_reg       <= 1'b0;
         reload_reg   <= 1'b0;
         irq_en_reg   <= 1'b0;
         prescale_reg <= '0;
         pre_cnt_reg  <= '0;
         compare_reg  <= '0;
         count_reg    <= '0;
         match_reg    <= 1'b0;
      end else begin
         en_reg       <= en_next;
         reload_reg   <= reload_next;
         irq_en_reg   <= irq_en_next;
         prescale_reg <= prescale_next;
         pre_cnt_reg  <= pre_cnt_next;
         compare_reg  <= compare_next;
         count_reg    <= count_next;
         match_reg    <= match_next;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         rd_word[i] = '0;
      end
      rd_word[OFF_CTRL]     = {29'd0, irq_en_reg, reload_reg, en_reg};
      rd_word[OFF_PRESCALE] = 32'(prescale_reg);
      rd_word[OFF_COMPARE]  = compare_reg;
      rd_word[OFF_COUNT]    = count_reg;
      rd_word[OFF_STATUS]   = {31'd0, match_reg};
   end

   assign bus.rd  = sel ? rd_word[offset] : 32'h0;
   assign bus.sel = sel;
   assign bus.irq = match_reg & irq_en_reg;
endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios with literal expectations, then random bus
// traffic checked every cycle against a register-level behavioural model.
module tb_mmio_timer;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mmio_timer_if bus ();

   mmio_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Model state: programmer-visible registers plus clocks elapsed since the last tick.
   bit        m_en = 0, m_reload = 0, m_irqen = 0, m_match = 0;
   bit [15:0] m_pre = 0, m_phase = 0;
   bit [31:0] m_cmp = 0, m_cnt = 0;

   task automatic model_edge(input logic rst, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
      bit wr, stopping, tk, hit;
      int off;
      if (rst) begin
         m_en = 0; m_reload = 0; m_irqen = 0; m_match = 0;
         m_pre = 0; m_phase = 0; m_cmp = 0; m_cnt = 0;
         return;
      end
      wr       = we && (a[31:5] == BASE[31:5]);
      off      = int'(a[4:2]);
      stopping = wr && off == 0 && !wd[0];
      tk       = m_en && (m_phase == m_pre) && !stopping;
      hit      = tk && (m_cnt == m_cmp);
      if (!m_en || tk || stopping || (wr && off == 1)) m_phase = 0;
      else m_phase = m_phase + 1;
      if (tk) m_cnt = hit ? (m_reload ? 32'd0 : m_cnt) : m_cnt + 1;
      if (hit) m_match = 1;
      else if (wr && off == 4 && wd[0]) m_match = 0;
      if (wr) begin
         case (off)
            0: begin m_en = wd[0]; m_reload = wd[1]; m_irqen = wd[2]; end
            1: m_pre = wd[15:0];
            2: m_cmp = wd;
            3: m_cnt = wd;
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'h0;
      case (a[4:2])
         3'd0: return {29'd0, m_irqen, m_reload, m_en};
         3'd1: return {16'd0, m_pre};
         3'd2: return m_cmp;
         3'd3: return m_cnt;
         3'd4: return {31'd0, m_match};
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge(reset, bus.we, bus.a, bus.wd);
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         check("sel", 32'(bus.sel), 32'(bus.a[31:5] == BASE[31:5]));
         check("rd", bus.rd, exp_rd(bus.a));
         check("irq", 32'(bus.irq), 32'(m_match & m_irqen));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input int off, input logic [31:0] d);
      bus.we = 1'b1;
      bus.a  = BASE + 32'(off * 4);
      bus.wd = d;
      step();
      bus.we = 1'b0;
   endtask

   task automatic peek(input int off, input string nm, input logic [31:0] exp);
      bus.we = 1'b0;
      bus.a  = BASE + 32'(off * 4);
      #1;
      check(nm, bus.rd, exp);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      bus.we = 1'b0;
      step();
      reset  = 1'b0;
   endtask

   initial begin
      int          off;
      logic [31:0] d, r;
      bus.we = 1'b0;
      bus.a  = 32'h0;
      bus.wd = 32'h0;
      step();
      chk_on = 1'b1;
      step();
      reset = 1'b0;

      // Reset state: every offset reads zero.
      for (int i = 0; i < 8; i++) begin
         peek(i, "t1_reset_rd", 32'h0);
         step();
      end

      // COUNT 0,1,2,3,0 with MATCH and irq rising on the fourth tick.
      bus_write(1, 32'd0);
      bus_write(2, 32'd3);
      bus_write(0, 32'd7);
      for (int k = 0; k < 8; k++) begin
         peek(3, "t2_count", 32'(k % 4));
         check("t2_irq", 32'(bus.irq), 32'(k >= 4));
         step();
      end

      // Reset mid-count.
      do_reset();
      peek(3, "t1_midreset_count", 32'h0);
      check("t1_midreset_irq", 32'(bus.irq), 32'h0);

      // Prescaled count without reload holds at COMPARE.
      bus_write(1, 32'd2);
      bus_write(2, 32'd1);
      bus_write(0, 32'd5);
      repeat (2) step();
      peek(3, "t3_count_before_tick", 32'd0);
      step();
      peek(3, "t3_count_first_tick", 32'd1);
      repeat (3) step();
      peek(4, "t3_status", 32'd1);
      peek(3, "t3_count_hold", 32'd1);
      repeat (3) step();
      peek(3, "t3_count_still_hold", 32'd1);

      // Wrap through 2^32, then match six ticks later.
      do_reset();
      bus_write(1, 32'd0);
      bus_write(2, 32'd5);
      bus_write(3, 32'hFFFF_FFFF);
      bus_write(0, 32'd1);
      peek(3, "t4_count_loaded", 32'hFFFF_FFFF);
      step();
      peek(3, "t4_count_wrapped", 32'd0);
      repeat (5) step();
      peek(3, "t4_count_5", 32'd5);
      peek(4, "t4_status_not_yet", 32'd0);
      step();
      peek(4, "t4_status_set", 32'd1);

      // Clear on the same edge as a match loses to the match.
      do_reset();
      bus_write(1, 32'd0);
      bus_write(2, 32'd2);
      bus_write(0, 32'd7);
      repeat (2) step();
      bus_write(4, 32'd1);
      peek(4, "t5_status_kept", 32'd1);
      bus_write(0, 32'd4);
      peek(4, "t5_status_after_stop", 32'd1);
      bus_write(4, 32'd1);
      peek(4, "t5_status_cleared", 32'd0);
      check("t5_irq_cleared", 32'(bus.irq), 32'h0);

      // Out-of-window and reserved addresses.
      bus.a = BASE + 32'h20;
      #1;
      check("t6_sel_outside", 32'(bus.sel), 32'h0);
      check("t6_rd_outside", bus.rd, 32'h0);
      step();
      bus.we = 1'b1;
      bus.wd = 32'h55;
      bus.a  = BASE + 32'h28;
      step();
      bus.a  = BASE + 32'h14;
      step();
      bus.we = 1'b0;
      peek(2, "t6_compare_intact", 32'd2);
      peek(5, "t6_reserved_rd", 32'h0);
      check("t6_sel_reserved", 32'(bus.sel), 32'h1);
      step();

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         off   = int'($urandom_range(0, 7));
         r     = $urandom;
         case (off)
            1:       d = (r & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            2:       d = 32'($urandom_range(0, 12));
            3:       d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 12));
            default: d = r;
         endcase
         bus.we = ($urandom_range(0, 3) == 0);
         bus.a  = ($urandom_range(0, 15) == 0) ? $urandom
                                               : BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         bus.wd = d;
         step();
      end
      reset  = 1'b0;
      bus.we = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
